// File: rtl/imem_fetch_ctrl_if.sv
// Fetch-controller bus: control pulses, instruction-memory port, decode handshake and status.
// The master side is whoever drives control and supplies memory data; the slave is the fetch controller.
interface imem_fetch_ctrl_if;
    logic        start;
    logic        stop;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        busy;
    logic        fault;
    logic [31:0] fault_addr;

    modport master (
        output start, stop, redirect_valid, redirect_pc, imem_rdata, out_ready,
        input  imem_addr, out_valid, out_instr, out_pc, busy, fault, fault_addr
    );

    modport slave (
        input  start, stop, redirect_valid, redirect_pc, imem_rdata, out_ready,
        output imem_addr, out_valid, out_instr, out_pc, busy, fault, fault_addr
    );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: owns the fetch PC, reads one word per cycle into a
// small FIFO feeding decode, and handles redirect, start/stop and sticky address faults.
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 1024,
    parameter int unsigned DEPTH      = 2
) (
    input  logic              clk,
    input  logic              rst,
    imem_fetch_ctrl_if.slave  bus
);

    localparam int unsigned        PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned        CNT_W    = PTR_W + 1;
    localparam logic [32:0]        PC_LIMIT = 33'(IMEM_WORDS) << 2;
    localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FAULT = 2'b10
    } state_t;

    state_t             r_state;
    logic [31:0]        r_fetch_pc;
    logic [31:0]        r_fifo_pc    [DEPTH];
    logic [31:0]        r_fifo_instr [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_busy;
    logic               r_fault;
    logic [31:0]        r_fault_addr;

    logic               w_pop;
    logic               w_slot;
    logic               w_pc_oob;
    logic               w_redir;
    logic               w_redir_bad;
    logic               w_push;
    logic               w_run_fault;

    // Handshake, push-slot and range decisions for the coming edge.
    always_comb begin
        w_pop       = (r_count != CNT_W'(0)) && bus.out_ready;
        // A full FIFO still accepts a word when the head leaves on the same edge.
        w_slot      = (r_count < CNT_FULL) || w_pop;
        w_pc_oob    = ({1'b0, r_fetch_pc} >= PC_LIMIT);
        w_redir     = bus.redirect_valid && (r_state != ST_FAULT);
        w_redir_bad = (bus.redirect_pc[1:0] != 2'b00) || ({1'b0, bus.redirect_pc} >= PC_LIMIT);
        w_push      = !w_redir && (r_state == ST_RUN) && w_slot && !w_pc_oob;
        w_run_fault = !w_redir && (r_state == ST_RUN) && w_slot && w_pc_oob;
    end

    // State machine, fetch PC, FIFO storage and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_fetch_pc   <= RESET_PC;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_busy       <= 1'b0;
            r_fault      <= 1'b0;
            r_fault_addr <= 32'h0000_0000;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_fifo_pc[i]    <= 32'h0000_0000;
                r_fifo_instr[i] <= 32'h0000_0000;
            end
        end else if (w_redir) begin
            // Flush; any head taken on this edge is simply dropped with the rest.
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            if (w_redir_bad) begin
                r_state      <= ST_FAULT;
                r_busy       <= 1'b0;
                r_fault      <= 1'b1;
                r_fault_addr <= bus.redirect_pc;
            end else begin
                r_fetch_pc   <= bus.redirect_pc;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start && !bus.stop) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_run_fault) begin
                        r_state      <= ST_FAULT;
                        r_busy       <= 1'b0;
                        r_fault      <= 1'b1;
                        r_fault_addr <= r_fetch_pc;
                    end else if (bus.stop) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_FAULT: begin
                    r_state <= ST_FAULT;
                end
                default: begin
                    r_state <= ST_FAULT;
                    r_busy  <= 1'b0;
                    r_fault <= 1'b1;
                end
            endcase

            if (w_push) begin
                r_fifo_pc[r_wr_ptr]    <= r_fetch_pc;
                r_fifo_instr[r_wr_ptr] <= bus.imem_rdata;
                r_wr_ptr               <= r_wr_ptr + PTR_W'(1);
                r_fetch_pc             <= r_fetch_pc + 32'd4;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.imem_addr  = r_fetch_pc;
    assign bus.out_valid  = (r_count != CNT_W'(0));
    assign bus.out_instr  = r_fifo_instr[r_rd_ptr];
    assign bus.out_pc     = r_fifo_pc[r_rd_ptr];
    assign bus.busy       = r_busy;
    assign bus.fault      = r_fault;
    assign bus.fault_addr = r_fault_addr;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: a vector table for the main fetch/stall/redirect/range
// flow, then hand-written sequences for start/stop, bad redirects and async reset.
module tb_imem_fetch_ctrl;

    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;

    imem_fetch_ctrl_if bus ();

    imem_fetch_ctrl #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_WORDS (1024),
        .DEPTH      (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: word i holds the value i.
    always_comb bus.imem_rdata = {2'b00, bus.imem_addr[31:2]};

    typedef struct {
        logic        start;
        logic        stop;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] ei;
        logic        eb;
        logic        ef;
        logic [31:0] efa;
        logic [31:0] ea;
    } vec_t;

    vec_t vecs [21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_all(input string tag, input logic ev, input logic [31:0] epc,
                             input logic [31:0] ei, input logic eb, input logic ef,
                             input logic [31:0] efa, input logic [31:0] ea);
        chk({tag, ".out_valid"}, {31'b0, bus.out_valid}, {31'b0, ev});
        if (ev) begin
            chk({tag, ".out_pc"}, bus.out_pc, epc);
            chk({tag, ".out_instr"}, bus.out_instr, ei);
        end
        chk({tag, ".busy"}, {31'b0, bus.busy}, {31'b0, eb});
        chk({tag, ".fault"}, {31'b0, bus.fault}, {31'b0, ef});
        chk({tag, ".fault_addr"}, bus.fault_addr, efa);
        chk({tag, ".imem_addr"}, bus.imem_addr, ea);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".out_valid"}, {31'b0, bus.out_valid}, 32'd0);
        chk({tag, ".out_pc"}, bus.out_pc, 32'd0);
        chk({tag, ".out_instr"}, bus.out_instr, 32'd0);
        chk({tag, ".busy"}, {31'b0, bus.busy}, 32'd0);
        chk({tag, ".fault"}, {31'b0, bus.fault}, 32'd0);
        chk({tag, ".fault_addr"}, bus.fault_addr, 32'd0);
        chk({tag, ".imem_addr"}, bus.imem_addr, 32'd0);
    endtask

    task automatic step(input logic st, input logic sp, input logic rv,
                        input logic [31:0] rpc, input logic rdy);
        bus.start          = st;
        bus.stop           = sp;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.out_ready      = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst                = 1'b1;
        bus.start          = 1'b0;
        bus.stop           = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.out_ready      = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;

        // start stop rv rpc rdy | valid pc instr busy fault faddr imem_addr
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,     1'b1, 1'b0, 32'h0,     32'h0,   1'b1, 1'b0, 32'h0,    32'h0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 32'h0,     32'h0,   1'b1, 1'b0, 32'h0,    32'h4};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 32'h4,     32'h1,   1'b1, 1'b0, 32'h0,    32'h8};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 32'h8,     32'h2,   1'b1, 1'b0, 32'h0,    32'hC};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 32'h8,     32'h2,   1'b1, 1'b0, 32'h0,    32'h10};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 32'h8,     32'h2,   1'b1, 1'b0, 32'h0,    32'h10};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 32'h8,     32'h2,   1'b1, 1'b0, 32'h0,    32'h10};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 32'h8,     32'h2,   1'b1, 1'b0, 32'h0,    32'h10};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 32'h8,     32'h2,   1'b1, 1'b0, 32'h0,    32'h10};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 32'hC,     32'h3,   1'b1, 1'b0, 32'h0,    32'h14};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 32'h10,    32'h4,   1'b1, 1'b0, 32'h0,    32'h18};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 32'h40,    1'b1, 1'b0, 32'h0,     32'h0,   1'b1, 1'b0, 32'h0,    32'h40};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 32'h40,    32'h10,  1'b1, 1'b0, 32'h0,    32'h44};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 32'h44,    32'h11,  1'b1, 1'b0, 32'h0,    32'h48};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 32'hFF8,   1'b1, 1'b0, 32'h0,     32'h0,   1'b1, 1'b0, 32'h0,    32'hFF8};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 32'hFF8,   32'h3FE, 1'b1, 1'b0, 32'h0,    32'hFFC};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 32'hFFC,   32'h3FF, 1'b1, 1'b0, 32'h0,    32'h1000};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 32'hFFC,   32'h3FF, 1'b0, 1'b1, 32'h1000, 32'h1000};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 32'h0,     1'b1, 1'b0, 32'h0,     32'h0,   1'b0, 1'b1, 32'h1000, 32'h1000};
        vecs[19] = '{1'b0, 1'b0, 1'b1, 32'h40,    1'b1, 1'b0, 32'h0,     32'h0,   1'b0, 1'b1, 32'h1000, 32'h1000};
        vecs[20] = '{1'b1, 1'b0, 1'b0, 32'h0,     1'b1, 1'b0, 32'h0,     32'h0,   1'b0, 1'b1, 32'h1000, 32'h1000};

        do_reset();
        check_reset("reset");

        for (int i = 0; i < 21; i++) begin
            step(vecs[i].start, vecs[i].stop, vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
            check_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].epc, vecs[i].ei,
                      vecs[i].eb, vecs[i].ef, vecs[i].efa, vecs[i].ea);
        end

        // start+stop together, IDLE redirect, stop with a same-edge push, drain in IDLE
        do_reset();
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        check_all("ss_both", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check_all("ss_idle", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h100, 1'b0);
        check_all("idle_redir", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h100);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check_all("idle_nopush", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h100);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        check_all("ss_start", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h100);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check_all("ss_push", 1'b1, 32'h100, 32'h40, 1'b1, 1'b0, 32'h0, 32'h104);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        check_all("ss_stop", 1'b1, 32'h100, 32'h40, 1'b0, 1'b0, 32'h0, 32'h108);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check_all("ss_hold", 1'b1, 32'h100, 32'h40, 1'b0, 1'b0, 32'h0, 32'h108);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check_all("ss_drain1", 1'b1, 32'h104, 32'h41, 1'b0, 1'b0, 32'h0, 32'h108);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check_all("ss_drain2", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h108);

        // misaligned redirect
        do_reset();
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check_all("mis_pre", 1'b1, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h4);
        step(1'b0, 1'b0, 1'b1, 32'h42, 1'b0);
        check_all("mis_fault", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h42, 32'h4);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check_all("mis_nopush", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h42, 32'h4);

        // out-of-range redirect
        do_reset();
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 32'h1000, 1'b1);
        check_all("oor_fault", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h1000, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check_all("oor_nopush", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h1000, 32'h0);

        // async reset mid-cycle with a full FIFO
        do_reset();
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check_all("ar_full", 1'b1, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h8);
        #2 rst = 1'b1;
        #1;
        check_reset("ar_async");
        @(posedge clk);
        #1 rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
